// File: rtl/pixel_plot_sink.sv
// Receiving end of the GUI pixel interface: range-checks plot strobes, queues them
// in a small FIFO and drains them to the framebuffer write port; also runs clear sweeps.
module pixel_plot_sink #(
   parameter int unsigned WIDTH          = 160,
   parameter int unsigned HEIGHT         = 120,
   parameter int unsigned DEPTH          = 4,
   parameter logic [2:0]  CLEAR_COLOUR   = 3'b111,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  colour,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic        plot,
   input  logic        clear_req,
   input  logic        mem_grant,
   output logic [14:0] mem_addr,
   output logic [2:0]  mem_data,
   output logic        mem_we,
   output logic        busy,
   output logic        clear_done,
   output logic        fifo_full,
   output logic [7:0]  oob_count,
   output logic [7:0]  ovf_count
);

   localparam int unsigned PW        = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C   = (PW+1)'(DEPTH);
   localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CLEAR} state_t;

   typedef struct packed {
      logic [14:0] addr;
      logic [2:0]  col;
   } entry_t;

   entry_t      fifo_q [DEPTH];
   entry_t      fifo_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   state_t      state_q, state_d;
   logic [14:0] sweep_q, sweep_d;
   logic        mem_we_q, mem_we_d, busy_q, busy_d;
   logic [14:0] mem_addr_q, mem_addr_d;
   logic [2:0]  mem_data_q, mem_data_d;
   logic [7:0]  oob_q, oob_d, ovf_q, ovf_d;

   logic   in_range, pop, push;
   entry_t new_entry, head_d;

   always_comb begin
      in_range       = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
      new_entry.addr = 15'(32'(y) * WIDTH + 32'(x));
      new_entry.col  = colour;

      pop  = (state_q == ST_RUN) && mem_we_q && mem_grant;
      push = plot && in_range && ((count_q < DEPTH_C) || pop);

      fifo_d = fifo_q;
      if (push) fifo_d[wr_ptr_q] = new_entry;
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);

      // Next head bypasses the array when it is the entry being written this edge.
      head_d = (push && (rd_ptr_d == wr_ptr_q)) ? new_entry : fifo_q[rd_ptr_d];

      oob_d = oob_q;
      ovf_d = ovf_q;
      if (plot && !in_range && (oob_q != 8'hFF)) oob_d = oob_q + 8'd1;
      if (plot && in_range && !push && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;

      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         ST_INIT: begin
            state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            sweep_d = '0;
         end
         ST_RUN: begin
            if (clear_req && !mem_we_q) begin
               state_d = ST_CLEAR;
               sweep_d = '0;
            end
         end
         ST_CLEAR: begin
            if (mem_grant) begin
               if (sweep_q == LAST_ADDR) state_d = ST_RUN;
               else                      sweep_d = sweep_q + 15'd1;
            end
         end
         default: state_d = ST_INIT;
      endcase

      busy_d     = (state_d == ST_CLEAR);
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      if (state_d == ST_CLEAR) begin
         mem_we_d   = 1'b1;
         mem_addr_d = sweep_d;
         mem_data_d = CLEAR_COLOUR;
      end else if (count_d != '0) begin
         mem_we_d   = 1'b1;
         mem_addr_d = head_d.addr;
         mem_data_d = head_d.col;
      end else begin
         mem_we_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_INIT;
         sweep_q    <= '0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         oob_q      <= '0;
         ovf_q      <= '0;
      end else begin
         fifo_q     <= fifo_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         mem_we_q   <= mem_we_d;
         busy_q     <= busy_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         oob_q      <= oob_d;
         ovf_q      <= ovf_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign busy       = busy_q;
   assign fifo_full  = (count_q == DEPTH_C);
   assign oob_count  = oob_q;
   assign ovf_count  = ovf_q;
   assign clear_done = (state_q == ST_CLEAR) && mem_grant && (sweep_q == LAST_ADDR);

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Randomised and directed checks of pixel_plot_sink against a queue-based model.
module tb_pixel_plot_sink;

   localparam int W    = 160;
   localparam int H    = 120;
   localparam int D    = 4;
   localparam int LAST = W * H - 1;

   logic        clock, reset;
   logic [2:0]  colour;
   logic [7:0]  x;
   logic [6:0]  y;
   logic        plot, clear_req, mem_grant;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_we, busy, clear_done, fifo_full;
   logic [7:0]  oob_count, ovf_count;

   pixel_plot_sink #(
      .WIDTH(160), .HEIGHT(120), .DEPTH(4),
      .CLEAR_COLOUR(3'b111), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clock(clock), .reset(reset), .colour(colour), .x(x), .y(y),
      .plot(plot), .clear_req(clear_req), .mem_grant(mem_grant),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .busy(busy), .clear_done(clear_done), .fifo_full(fifo_full),
      .oob_count(oob_count), .ovf_count(ovf_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int addr;
      int col;
   } px_t;

   int  total = 0;
   int  bad   = 0;

   // model: mode 0 = just out of reset, 1 = run, 2 = clear sweep
   px_t mq[$];
   int  m_mode, m_sweep, m_oob, m_ovf;

   px_t wlog[$];
   int  done_seen, clear_wr_seen;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_mode  = 0;
      m_sweep = 0;
      m_oob   = 0;
      m_ovf   = 0;
   endtask

   task automatic model_step(input bit p, input int px, input int py, input int pc,
                             input bit clr, input bit g);
      bit  was_empty;
      px_t tmp;
      was_empty = (mq.size() == 0);
      if (m_mode == 1 && !was_empty && g) tmp = mq.pop_front();
      if (p) begin
         if (px >= W || py >= H) begin
            if (m_oob < 255) m_oob++;
         end else if (mq.size() < D) begin
            mq.push_back('{py * W + px, pc});
         end else if (m_ovf < 255) begin
            m_ovf++;
         end
      end
      case (m_mode)
         0: begin m_mode = 2; m_sweep = 0; end
         1: if (clr && was_empty) begin m_mode = 2; m_sweep = 0; end
         default: if (g) begin
            if (m_sweep == LAST) m_mode = 1;
            else m_sweep++;
         end
      endcase
   endtask

   task automatic check_outputs();
      bit exp_we;
      exp_we = (m_mode == 2) || (m_mode == 1 && mq.size() > 0);
      check("mem_we", mem_we, exp_we);
      check("busy", busy, m_mode == 2);
      check("fifo_full", fifo_full, mq.size() == D);
      check("oob_count", oob_count, m_oob);
      check("ovf_count", ovf_count, m_ovf);
      if (exp_we && mem_we) begin
         check("mem_addr", mem_addr, (m_mode == 2) ? m_sweep : mq[0].addr);
         check("mem_data", mem_data, (m_mode == 2) ? 7 : mq[0].col);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_busy", busy, 0);
      check("rst_clear_done", clear_done, 0);
      check("rst_fifo_full", fifo_full, 0);
      check("rst_oob", oob_count, 0);
      check("rst_ovf", ovf_count, 0);
   endtask

   // Called at posedge+1; drives inputs, checks clear_done at negedge, steps the model at posedge.
   task automatic cyc(input bit p, input int px, input int py, input int pc,
                      input bit clr, input bit g);
      plot = p; x = 8'(px); y = 7'(py); colour = 3'(pc);
      clear_req = clr; mem_grant = g;
      @(negedge clock);
      check("clear_done", clear_done, (m_mode == 2 && g && m_sweep == LAST));
      if (clear_done) done_seen++;
      if (mem_we && g) begin
         wlog.push_back('{int'(mem_addr), int'(mem_data)});
         if (busy) clear_wr_seen++;
      end
      @(posedge clock);
      model_step(p, px, py, pc, clr, g);
      #1 check_outputs();
   endtask

   initial begin
      int n;
      int exp_a[4];
      bit g, p, clr;

      reset = 1'b0; plot = 0; x = '0; y = '0; colour = '0; clear_req = 0; mem_grant = 1'b1;
      done_seen = 0; clear_wr_seen = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1 check_reset_outputs();
      reset = 1'b1;

      // power-up clear sweep with grant always high
      cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < W * H; i++) cyc(0, 0, 0, 0, 0, 1);
      check("sweep_writes", clear_wr_seen, 19200);
      check("sweep_done_pulses", done_seen, 1);
      check("sweep_last_addr", wlog[wlog.size() - 1].addr, 19199);
      check("sweep_end_busy", busy, 0);

      // single pixel latency
      cyc(1, 5, 2, 1, 0, 1);
      check("px_we", mem_we, 1);
      check("px_addr", mem_addr, 325);
      check("px_data", mem_data, 1);
      cyc(0, 0, 0, 0, 0, 1);
      check("px_drained", mem_we, 0);

      // fill with grant low, two overflows, then drain in order
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 159, 0, 2, 0, 0);
      cyc(1, 0, 1, 3, 0, 0);
      cyc(1, 159, 119, 4, 0, 0);
      cyc(1, 10, 10, 5, 0, 0);
      cyc(1, 1, 1, 6, 0, 0);
      check("fill_full", fifo_full, 1);
      check("fill_ovf", ovf_count, 2);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
      exp_a = '{0, 159, 160, 19199};
      for (int i = 0; i < 4; i++)
         check("drain_order", wlog[wlog.size() - 4 + i].addr, exp_a[i]);
      check("drain_empty", mem_we, 0);

      // out-of-range plots
      cyc(1, 160, 0, 5, 0, 1);
      cyc(1, 0, 120, 5, 0, 1);
      check("oob_two", oob_count, 2);
      check("oob_no_write", mem_we, 0);

      // push into a full FIFO on a pop cycle
      for (int i = 1; i <= 4; i++) cyc(1, i, 0, 2, 0, 0);
      check("full_before", fifo_full, 1);
      cyc(1, 7, 3, 6, 0, 1);
      check("full_pop_push_ovf", ovf_count, 2);
      check("full_pop_push_full", fifo_full, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
      check("full_last_addr", wlog[wlog.size() - 1].addr, 487);
      check("full_last_data", wlog[wlog.size() - 1].col, 6);

      // clear request behind queued pixels, then reset mid-sweep
      cyc(1, 3, 4, 2, 0, 0);
      cyc(1, 8, 9, 5, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 1);
      check("creq_w0", wlog[wlog.size() - 4].addr, 643);
      check("creq_w1", wlog[wlog.size() - 3].addr, 1448);
      check("creq_s0", wlog[wlog.size() - 2].addr, 0);
      check("creq_s1", wlog[wlog.size() - 1].addr, 1);
      check("creq_s0_col", wlog[wlog.size() - 2].col, 7);
      check("creq_busy", busy, 1);
      reset = 1'b0;
      #2 check_reset_outputs();
      repeat (3) @(posedge clock);
      #1 check_reset_outputs();
      reset = 1'b1;
      model_reset();
      done_seen = 0;

      // randomised sweep and run traffic
      n = 0;
      while (n < 60000) begin
         g   = ($urandom % 4) != 0;
         p   = $urandom % 2;
         clr = (m_mode == 2) ? 1'($urandom % 2) : 1'b0;
         cyc(p, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7), clr, g);
         n++;
         if (m_mode == 1) break;
      end
      if (n >= 60000) begin
         total++; bad++;
         $display("FAIL sweep_timeout: got no completion after %0d cycles, expected completion", n);
      end
      check("rand_done_pulses", done_seen, 1);
      for (int i = 0; i < 3000; i++) begin
         g = ($urandom % 4) != 0;
         p = ($urandom % 3) != 0;
         cyc(p, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7), 1'b0, g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
